// File: rtl/sys_arr_row_dbuf.sv
// rtl/sys_arr_row_dbuf.sv - systolic-array MAC row with double-buffered weights
//
// Purpose:
//   One row of ROW_WIDTH multiply-accumulate PEs. Activations ripple left to
//   right through a register per PE. Each PE adds x_i*w_i to the partial sum
//   arriving from the row above and registers the result for the row below.
//   Weights are double-buffered: a shadow bank fills through a valid/ready
//   port while the active bank computes. An atomic swap then promotes the
//   shadow bank in a single edge.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset
//   data_in        in   DATA_W signed activation entering PE0
//   data_in_valid  in   qualifies data_in
//   sumin          in   N*ACC_W partial sums, PE i uses [i*ACC_W +: ACC_W]
//   maccout        out  N*ACC_W registered partial sums, same slicing
//   maccout_valid  out  N per-PE result valid
//   sat_flag       out  N per-PE pulse, result was clamped (SAT=1 only)
//   data_out       out  DATA_W activation leaving PE N-1
//   data_out_valid out  qualifies data_out
//   wload_data     in   shadow weight word
//   wload_valid    in   weight word offered
//   wload_ready    out  shadow bank can accept a word
//   wswap          in   promote shadow bank to active
//   wswap_err      out  one-cycle pulse, swap requested while shadow not full
//   shadow_full    out  shadow bank holds N words

module sys_arr_row_dbuf #(
  parameter int ROW_WIDTH = 4,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,
  parameter int SAT       = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [DATA_W-1:0]      data_in,
  input  logic                          data_in_valid,
  input  logic [ROW_WIDTH*ACC_W-1:0]    sumin,
  output logic [ROW_WIDTH*ACC_W-1:0]    maccout,
  output logic [ROW_WIDTH-1:0]          maccout_valid,
  output logic [ROW_WIDTH-1:0]          sat_flag,
  output logic signed [DATA_W-1:0]      data_out,
  output logic                          data_out_valid,
  input  logic signed [DATA_W-1:0]      wload_data,
  input  logic                          wload_valid,
  output logic                          wload_ready,
  input  logic                          wswap,
  output logic                          wswap_err,
  output logic                          shadow_full
);

  localparam int N   = ROW_WIDTH;
  localparam int CW  = $clog2(N + 1);
  // Sign-extension needed to bring the full product up to the ACC_W+1 sum width.
  localparam int EXT = ACC_W + 1 - 2 * DATA_W;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_FILLING = 2'd1,
    S_FULL    = 2'd2
  } wstate_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] r_d       [N];
  logic [N-1:0]             r_v;
  logic [ACC_W-1:0]         r_macc    [N];
  logic [N-1:0]             r_mvalid;
  logic [N-1:0]             r_sat;
  logic signed [DATA_W-1:0] r_wact    [N];
  logic signed [DATA_W-1:0] r_wshadow [N];

  wstate_t                  r_state;
  wstate_t                  w_state_next;
  logic [CW-1:0]            r_wcount;
  logic [CW-1:0]            w_wcount_next;
  logic                     r_wswap_err;

  logic                     w_ready;
  logic                     w_accept;
  logic                     w_swap_ok;
  logic                     w_swap_err;

  // Per-PE combinational MAC results.
  logic [N-1:0]             w_xv;
  logic [N-1:0]             w_ovf;
  logic [N-1:0]             w_satp;
  logic [ACC_W-1:0]         w_res [N];

  // ---------------------------------------------------------------------------
  // Processing elements
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N; gi++) begin : g_pe
    logic signed [DATA_W-1:0]   w_x;
    logic [2*DATA_W-1:0]        w_xe;
    logic [2*DATA_W-1:0]        w_we;
    logic [2*DATA_W-1:0]        w_prod;
    logic [ACC_W-1:0]           w_sumin;
    logic [ACC_W:0]             w_sum;

    // PE0 sees the live input; later PEs see the previous PE's data register,
    // so the operand and its valid line up with the data pipe.
    if (gi == 0) begin : g_first
      assign w_x      = data_in;
      assign w_xv[gi] = data_in_valid;
    end else begin : g_rest
      assign w_x      = r_d[gi-1];
      assign w_xv[gi] = r_v[gi-1];
    end

    // Operands are sign-extended to the product width so the low 2*DATA_W
    // bits of the multiply are the exact signed product.
    assign w_xe    = {{DATA_W{w_x[DATA_W-1]}}, w_x};
    assign w_we    = {{DATA_W{r_wact[gi][DATA_W-1]}}, r_wact[gi]};
    assign w_prod  = w_xe * w_we;
    assign w_sumin = sumin[gi*ACC_W +: ACC_W];

    // One guard bit is enough: both addends fit in ACC_W signed bits.
    assign w_sum   = {{EXT{w_prod[2*DATA_W-1]}}, w_prod}
                   + {w_sumin[ACC_W-1], w_sumin};

    // Overflow when the guard bit disagrees with the ACC_W sign bit.
    assign w_ovf[gi]  = (w_sum[ACC_W] != w_sum[ACC_W-1]);
    assign w_satp[gi] = (SAT != 0) && w_xv[gi] && w_ovf[gi];

    always_comb begin
      w_res[gi] = w_sum[ACC_W-1:0];
      if ((SAT != 0) && w_ovf[gi]) begin
        w_res[gi] = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end
    end

    assign maccout[gi*ACC_W +: ACC_W] = r_macc[gi];
  end

  // ---------------------------------------------------------------------------
  // Data pipe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_d[i] <= '0;
      end
      r_v <= '0;
    end else begin
      r_d[0] <= data_in;
      r_v[0] <= data_in_valid;
      for (int i = 1; i < N; i++) begin
        r_d[i] <= r_d[i-1];
        r_v[i] <= r_v[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // MAC result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_macc[i] <= '0;
      end
      r_mvalid <= '0;
      r_sat    <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        // An invalid operand leaves the last result in place for the row below.
        if (w_xv[i]) begin
          r_macc[i] <= w_res[i];
        end
      end
      r_mvalid <= w_xv;
      r_sat    <= w_satp;
    end
  end

  // ---------------------------------------------------------------------------
  // Weight FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_wcount    <= '0;
      r_wswap_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_wcount    <= w_wcount_next;
      r_wswap_err <= w_swap_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Weight FSM: next state and decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_wcount_next = r_wcount;
    w_ready       = (r_state != S_FULL);
    w_accept      = wload_valid && (r_state != S_FULL);
    w_swap_ok     = 1'b0;
    w_swap_err    = 1'b0;

    case (r_state)
      S_EMPTY, S_FILLING: begin
        // A swap racing the last word still sees a partial bank and is refused.
        if (wswap) begin
          w_swap_err = 1'b1;
        end
        if (w_accept) begin
          w_wcount_next = r_wcount + CW'(1);
          w_state_next  = (r_wcount == CW'(N - 1)) ? S_FULL : S_FILLING;
        end
      end
      S_FULL: begin
        if (wswap) begin
          w_swap_ok     = 1'b1;
          w_state_next  = S_EMPTY;
          w_wcount_next = '0;
        end
      end
      default: begin
        w_state_next  = S_EMPTY;
        w_wcount_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Weight banks
  // ---------------------------------------------------------------------------
  // The active bank only changes on the swap edge, so a MAC on that edge still
  // uses the old weights and the next edge uses the new ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_wact[i]    <= '0;
        r_wshadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_accept && (r_wcount == CW'(i))) begin
          r_wshadow[i] <= wload_data;
        end
        if (w_swap_ok) begin
          r_wact[i] <= r_wshadow[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign maccout_valid  = r_mvalid;
  assign sat_flag       = r_sat;
  assign data_out       = r_d[N-1];
  assign data_out_valid = r_v[N-1];
  assign wload_ready    = w_ready;
  assign shadow_full    = (r_state == S_FULL);
  assign wswap_err      = r_wswap_err;

endmodule

// File: tb/tb_sys_arr_row_dbuf.sv
// tb/tb_sys_arr_row_dbuf.sv - directed bench for sys_arr_row_dbuf

module tb_sys_arr_row_dbuf;

  logic              clk;
  logic              reset;
  logic [7:0]        data_in;
  logic              data_in_valid;
  logic [63:0]       sumin;
  logic [63:0]       maccout;
  logic [3:0]        maccout_valid;
  logic [3:0]        sat_flag;
  logic [7:0]        data_out;
  logic              data_out_valid;
  logic [7:0]        wload_data;
  logic              wload_valid;
  logic              wload_ready;
  logic              wswap;
  logic              wswap_err;
  logic              shadow_full;

  logic [63:0]       maccout_w;
  logic [3:0]        maccout_valid_w;
  logic [3:0]        sat_flag_w;
  logic [7:0]        data_out_w;
  logic              data_out_valid_w;
  logic              wload_ready_w;
  logic              wswap_err_w;
  logic              shadow_full_w;

  int n_checks = 0;
  int n_pass   = 0;

  sys_arr_row_dbuf #(.ROW_WIDTH(4), .DATA_W(8), .ACC_W(16), .SAT(1)) dut (
    .clk(clk), .reset(reset),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .sumin(sumin), .maccout(maccout), .maccout_valid(maccout_valid),
    .sat_flag(sat_flag), .data_out(data_out), .data_out_valid(data_out_valid),
    .wload_data(wload_data), .wload_valid(wload_valid), .wload_ready(wload_ready),
    .wswap(wswap), .wswap_err(wswap_err), .shadow_full(shadow_full)
  );

  sys_arr_row_dbuf #(.ROW_WIDTH(4), .DATA_W(8), .ACC_W(16), .SAT(0)) dut_w (
    .clk(clk), .reset(reset),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .sumin(sumin), .maccout(maccout_w), .maccout_valid(maccout_valid_w),
    .sat_flag(sat_flag_w), .data_out(data_out_w), .data_out_valid(data_out_valid_w),
    .wload_data(wload_data), .wload_valid(wload_valid), .wload_ready(wload_ready_w),
    .wswap(wswap), .wswap_err(wswap_err_w), .shadow_full(shadow_full_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input logic [15:0] a0, input logic [15:0] a1,
                                     input logic [15:0] a2, input logic [15:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [63:0] rep(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_n(input int n, input logic [7:0] base, input logic [7:0] step);
    for (int k = 0; k < n; k++) begin
      wload_valid = 1'b1;
      wload_data  = base + 8'(k) * step;
      n_checks++;
      if (wload_ready !== 1'b1) $display("FAIL load_ready: got %b want 1", wload_ready);
      else n_pass++;
      tick();
    end
    wload_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (maccout !== 64'd0) $display("FAIL rst_maccout: got %h want 0", maccout);
    else n_pass++;
    n_checks++;
    if ({maccout_valid, sat_flag, data_out_valid, wswap_err} !== 10'd0)
      $display("FAIL rst_flags: got %b want 0", {maccout_valid, sat_flag, data_out_valid, wswap_err});
    else n_pass++;
    n_checks++;
    if (data_out !== 8'd0) $display("FAIL rst_data_out: got %h want 0", data_out);
    else n_pass++;
    n_checks++;
    if ({wload_ready, shadow_full} !== 2'b10)
      $display("FAIL rst_wfsm: got %b want 10", {wload_ready, shadow_full});
    else n_pass++;
    wswap = 1'b1;
    tick();
    wswap = 1'b0;
    n_checks++;
    if (wswap_err !== 1'b1) $display("FAIL idle_swap_err: got %b want 1", wswap_err);
    else n_pass++;
    tick();
    n_checks++;
    if (wswap_err !== 1'b0) $display("FAIL idle_swap_err_pulse: got %b want 0", wswap_err);
    else n_pass++;
    // Active weights must still be zero: the result equals sumin.
    data_in = 8'd5; data_in_valid = 1'b1; sumin = rep(16'd10);
    tick();
    data_in_valid = 1'b0;
    n_checks++;
    if (maccout !== pk(16'd10, 16'd0, 16'd0, 16'd0))
      $display("FAIL idle_swap_noeffect: got %h want %h", maccout, pk(16'd10, 16'd0, 16'd0, 16'd0));
    else n_pass++;
    for (int k = 0; k < 4; k++) tick();
    n_checks++;
    if (maccout !== rep(16'd10)) $display("FAIL idle_drain: got %h want %h", maccout, rep(16'd10));
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [63:0] exp_m [4];
    exp_m[0] = pk(16'd15, 16'd10, 16'd10, 16'd10);
    exp_m[1] = pk(16'd15, 16'd20, 16'd10, 16'd10);
    exp_m[2] = pk(16'd15, 16'd20, 16'd25, 16'd10);
    exp_m[3] = pk(16'd15, 16'd20, 16'd25, 16'd30);
    load_n(4, 8'd1, 8'd1);
    n_checks++;
    if ({wload_ready, shadow_full} !== 2'b01)
      $display("FAIL basic_full: got %b want 01", {wload_ready, shadow_full});
    else n_pass++;
    wload_valid = 1'b1; wload_data = 8'd99;
    tick();
    wload_valid = 1'b0;
    n_checks++;
    if ({wload_ready, shadow_full} !== 2'b01)
      $display("FAIL basic_gap: got %b want 01", {wload_ready, shadow_full});
    else n_pass++;
    wswap = 1'b1;
    tick();
    wswap = 1'b0;
    n_checks++;
    if ({wswap_err, wload_ready, shadow_full} !== 3'b010)
      $display("FAIL basic_swap: got %b want 010", {wswap_err, wload_ready, shadow_full});
    else n_pass++;
    data_in = 8'd5; data_in_valid = 1'b1; sumin = rep(16'd10);
    tick();
    data_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (maccout_valid !== 4'(1 << k))
        $display("FAIL basic_mvalid%0d: got %b want %b", k, maccout_valid, 4'(1 << k));
      else n_pass++;
      n_checks++;
      if (maccout !== exp_m[k]) $display("FAIL basic_macc%0d: got %h want %h", k, maccout, exp_m[k]);
      else n_pass++;
      if (k < 3) tick();
    end
    n_checks++;
    if ({data_out_valid, data_out} !== {1'b1, 8'd5})
      $display("FAIL basic_data_out: got %b/%h want 1/05", data_out_valid, data_out);
    else n_pass++;
    tick();
    n_checks++;
    if ({maccout_valid, data_out_valid} !== 5'd0)
      $display("FAIL basic_idle_after: got %b want 0", {maccout_valid, data_out_valid});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    data_in = 8'd5; data_in_valid = 1'b1; sumin = rep(16'd10);
    wload_valid = 1'b1; wload_data = 8'hFF;
    for (int k = 0; k < 4; k++) tick();
    wload_valid = 1'b0;
    n_checks++;
    if ({maccout_valid, shadow_full, wload_ready} !== 6'b111110)
      $display("FAIL b2b_loaded: got %b want 111110", {maccout_valid, shadow_full, wload_ready});
    else n_pass++;
    n_checks++;
    if (maccout !== pk(16'd15, 16'd20, 16'd25, 16'd30))
      $display("FAIL b2b_pre_swap: got %h want %h", maccout, pk(16'd15, 16'd20, 16'd25, 16'd30));
    else n_pass++;
    wswap = 1'b1;
    tick();
    wswap = 1'b0;
    n_checks++;
    if (maccout !== pk(16'd15, 16'd20, 16'd25, 16'd30))
      $display("FAIL b2b_swap_edge_old_w: got %h want %h", maccout, pk(16'd15, 16'd20, 16'd25, 16'd30));
    else n_pass++;
    n_checks++;
    if ({wswap_err, shadow_full} !== 2'b00)
      $display("FAIL b2b_swap_ok: got %b want 00", {wswap_err, shadow_full});
    else n_pass++;
    tick();
    n_checks++;
    if (maccout !== rep(16'd5)) $display("FAIL b2b_new_w: got %h want %h", maccout, rep(16'd5));
    else n_pass++;
    data_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    n_checks++;
    if ({maccout_valid, data_out_valid} !== 5'd0 || maccout !== rep(16'd5))
      $display("FAIL b2b_drain: got %b/%h want 0/%h", {maccout_valid, data_out_valid}, maccout, rep(16'd5));
    else n_pass++;
  endtask

  task automatic test_saturation();
    load_n(4, 8'd127, 8'd0);
    wswap = 1'b1;
    tick();
    wswap = 1'b0;
    data_in = 8'd127; data_in_valid = 1'b1; sumin = rep(16'h7FF8);
    tick();
    n_checks++;
    if (maccout[15:0] !== 16'h7FFF) $display("FAIL sat_pos: got %h want 7fff", maccout[15:0]);
    else n_pass++;
    n_checks++;
    if (sat_flag !== 4'b0001) $display("FAIL sat_pos_flag: got %b want 0001", sat_flag);
    else n_pass++;
    n_checks++;
    if (maccout_w[15:0] !== 16'hBEF9 || sat_flag_w !== 4'b0000)
      $display("FAIL wrap_pos: got %h/%b want bef9/0000", maccout_w[15:0], sat_flag_w);
    else n_pass++;
    data_in = 8'h80; sumin = rep(16'h8008);
    tick();
    data_in_valid = 1'b0;
    n_checks++;
    if (maccout[15:0] !== 16'h8000) $display("FAIL sat_neg: got %h want 8000", maccout[15:0]);
    else n_pass++;
    n_checks++;
    if (sat_flag !== 4'b0001) $display("FAIL sat_neg_flag: got %b want 0001", sat_flag);
    else n_pass++;
    n_checks++;
    if (maccout_w[15:0] !== 16'h4088) $display("FAIL wrap_neg: got %h want 4088", maccout_w[15:0]);
    else n_pass++;
    tick();
    n_checks++;
    if (sat_flag !== 4'b0010) $display("FAIL sat_flag_move: got %b want 0010", sat_flag);
    else n_pass++;
    for (int k = 0; k < 3; k++) tick();
    n_checks++;
    if (sat_flag !== 4'b0000) $display("FAIL sat_flag_clear: got %b want 0000", sat_flag);
    else n_pass++;
  endtask

  task automatic test_swap_race();
    load_n(3, 8'd2, 8'd0);
    wload_valid = 1'b1; wload_data = 8'd2; wswap = 1'b1;
    tick();
    wload_valid = 1'b0; wswap = 1'b0;
    n_checks++;
    if ({wswap_err, shadow_full} !== 2'b11)
      $display("FAIL race_err_full: got %b want 11", {wswap_err, shadow_full});
    else n_pass++;
    data_in = 8'd1; data_in_valid = 1'b1; sumin = rep(16'd0);
    tick();
    data_in_valid = 1'b0;
    n_checks++;
    if (maccout[15:0] !== 16'd127) $display("FAIL race_old_w: got %h want 007f", maccout[15:0]);
    else n_pass++;
    n_checks++;
    if (wswap_err !== 1'b0) $display("FAIL race_err_pulse: got %b want 0", wswap_err);
    else n_pass++;
    wswap = 1'b1;
    tick();
    wswap = 1'b0;
    n_checks++;
    if ({wswap_err, shadow_full} !== 2'b00)
      $display("FAIL race_later_swap: got %b want 00", {wswap_err, shadow_full});
    else n_pass++;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    n_checks++;
    if (maccout[15:0] !== 16'd2) $display("FAIL race_new_w: got %h want 0002", maccout[15:0]);
    else n_pass++;
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_reset_midflight();
    load_n(2, 8'd7, 8'd0);
    data_in = 8'd3; data_in_valid = 1'b1; sumin = rep(16'd10);
    for (int k = 0; k < 3; k++) tick();
    wload_valid = 1'b1; wload_data = 8'd7; reset = 1'b1;
    tick();
    reset = 1'b0; wload_valid = 1'b0; data_in_valid = 1'b0;
    n_checks++;
    if (maccout !== 64'd0) $display("FAIL mid_rst_maccout: got %h want 0", maccout);
    else n_pass++;
    n_checks++;
    if ({maccout_valid, sat_flag, data_out_valid, wload_ready, shadow_full} !== 11'b00000000010)
      $display("FAIL mid_rst_flags: got %b want 00000000010",
               {maccout_valid, sat_flag, data_out_valid, wload_ready, shadow_full});
    else n_pass++;
    wswap = 1'b1;
    tick();
    wswap = 1'b0;
    n_checks++;
    if (wswap_err !== 1'b1) $display("FAIL mid_rst_swap_refused: got %b want 1", wswap_err);
    else n_pass++;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    n_checks++;
    if (maccout !== pk(16'd10, 16'd0, 16'd0, 16'd0))
      $display("FAIL mid_rst_w_cleared: got %h want %h", maccout, pk(16'd10, 16'd0, 16'd0, 16'd0));
    else n_pass++;
    load_n(4, 8'd1, 8'd0);
    n_checks++;
    if (shadow_full !== 1'b1) $display("FAIL mid_rst_reload_full: got %b want 1", shadow_full);
    else n_pass++;
    wswap = 1'b1;
    tick();
    wswap = 1'b0;
    n_checks++;
    if (wswap_err !== 1'b0) $display("FAIL mid_rst_reload_swap: got %b want 0", wswap_err);
    else n_pass++;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    n_checks++;
    if (maccout[15:0] !== 16'd13) $display("FAIL mid_rst_new_w: got %h want 000d", maccout[15:0]);
    else n_pass++;
    for (int k = 0; k < 4; k++) tick();
  endtask

  initial begin
    reset = 1'b1; data_in = 8'd0; data_in_valid = 1'b0; sumin = 64'd0;
    wload_data = 8'd0; wload_valid = 1'b0; wswap = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_swap_race();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
